// File: rtl/muxn_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muxn_reg_pkg
// Description : Shared datapath definitions for the muxn_reg operand-select
//               multiplexer: select-width helper, default out-of-range value
//               and error-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package muxn_reg_pkg;

    // Width of the optional out-of-range beat counter.
    localparam int MUXN_ERR_CNT_W = 8;

    // Value driven for a beat whose select does not address a real input.
    localparam logic [15:0] MUXN_DEFAULT_VAL = 16'h0000;

    // clog2 of the input count, never less than 1 so a 2:1 mux still has
    // a one-bit select.
    function automatic int muxn_sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage : muxn_reg_pkg
`default_nettype wire

// File: rtl/muxn_skid.sv
`default_nettype none
// ============================================================================
// Module      : muxn_skid
// Description : Generic WIDTH-bit 2-entry skid buffer with a registered
//               upstream ready. The main entry drives the output; the skid
//               entry catches one beat accepted while main is full and not
//               draining. Order is strictly first-in first-out.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               i_data   - upstream beat data
//               i_valid  - upstream beat valid
//               o_ready  - buffer can accept a beat (registered)
//               o_data   - head-of-line data (main entry)
//               o_valid  - main entry holds a beat
//               i_ready  - downstream accepts o_data
// Revision    : 1.0 - initial release
// ============================================================================
module muxn_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_in_ready;

    logic [WIDTH-1:0] w_main_data_nxt;
    logic             w_main_valid_nxt;
    logic [WIDTH-1:0] w_skid_data_nxt;
    logic             w_skid_valid_nxt;

    logic             w_accept;
    logic             w_consume;

    assign w_accept  = i_valid && r_in_ready;
    assign w_consume = r_main_valid && i_ready;

    always_comb begin
        w_main_data_nxt  = r_main_data;
        w_main_valid_nxt = r_main_valid;
        w_skid_data_nxt  = r_skid_data;
        w_skid_valid_nxt = r_skid_valid;

        if (!r_main_valid) begin
            // Skid is always empty while main is empty.
            if (w_accept) begin
                w_main_data_nxt  = i_data;
                w_main_valid_nxt = 1'b1;
            end
        end else if (w_consume) begin
            if (r_skid_valid) begin
                // Head drains: the older skid beat moves up. A new beat can
                // only be accepted when skid is empty, so it never races
                // this path, but it is routed to skid for completeness.
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = w_accept;
                if (w_accept) begin
                    w_skid_data_nxt = i_data;
                end
            end else if (w_accept) begin
                w_main_data_nxt = i_data;
            end else begin
                // Data is left in place; only the valid drops.
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_data_nxt  = i_data;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_data  <= w_main_data_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            // Ready is a flop copy of "skid empty", so it never depends
            // combinationally on the downstream ready.
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_data  = r_main_data;
    assign o_valid = r_main_valid;

endmodule : muxn_skid
`default_nettype wire

// File: rtl/muxn_reg.sv
`default_nettype none
// ============================================================================
// Module      : muxn_reg
// Description : Parametrised N:1 operand-select multiplexer with registered
//               output, valid/ready handshake through a 2-entry skid buffer,
//               deterministic out-of-range result and sticky select error.
//               Optional build macro MUXN_ERR_CNT_EN adds an 8-bit
//               saturating count of accepted out-of-range beats (ERR_CNT).
// Ports       : CLK       - rising-edge clock
//               RESET_N   - asynchronous active-low reset
//               I         - flattened inputs, input k at [k*WIDTH +: WIDTH]
//               S         - select, sampled with the input beat
//               IN_VALID  - upstream beat valid
//               IN_READY  - block can accept a beat (registered)
//               O         - selected data, registered
//               OUT_VALID - O holds a valid beat
//               OUT_READY - downstream accepts O
//               SEL_ERR   - sticky out-of-range select flag
//               ERR_SEL   - select of most recent out-of-range beat
//               CLR_ERR   - synchronous clear of SEL_ERR / ERR_SEL
//               ERR_CNT   - (MUXN_ERR_CNT_EN only) saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
module muxn_reg
    import muxn_reg_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NUM_IN      = 5,
    parameter int               SEL_W       = muxn_sel_width(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(MUXN_DEFAULT_VAL)
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [NUM_IN*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]        S,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [WIDTH-1:0]        O,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    SEL_ERR,
    output logic [SEL_W-1:0]        ERR_SEL,
    input  logic                    CLR_ERR
`ifdef MUXN_ERR_CNT_EN
    ,
    output logic [MUXN_ERR_CNT_W-1:0] ERR_CNT
`endif
);

    // One extra bit so NUM_IN == 2**SEL_W is representable; in that case
    // every select is in range.
    localparam logic [SEL_W:0] c_num_in = (SEL_W + 1)'(NUM_IN);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_in_range;
    logic             w_accept;
    logic             w_err_hit;
    logic             w_in_ready;

    logic             r_sel_err;
    logic [SEL_W-1:0] r_err_sel;

    // ------------------------------------------------------------------
    // Combinational select
    // ------------------------------------------------------------------
    assign w_in_range = ({1'b0, S} < c_num_in);

    always_comb begin
        w_sel_data = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (S == SEL_W'(k)) begin
                w_sel_data = I[k*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake / storage
    // ------------------------------------------------------------------
    muxn_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_data  (w_sel_data),
        .i_valid (IN_VALID),
        .o_ready (w_in_ready),
        .o_data  (O),
        .o_valid (OUT_VALID),
        .i_ready (OUT_READY)
    );

    assign IN_READY  = w_in_ready;
    assign w_accept  = IN_VALID && w_in_ready;
    assign w_err_hit = w_accept && !w_in_range;

    // ------------------------------------------------------------------
    // Sticky select error; a new error beats a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sel_err <= 1'b0;
            r_err_sel <= '0;
        end else if (w_err_hit) begin
            r_sel_err <= 1'b1;
            r_err_sel <= S;
        end else if (CLR_ERR) begin
            r_sel_err <= 1'b0;
            r_err_sel <= '0;
        end
    end

    assign SEL_ERR = r_sel_err;
    assign ERR_SEL = r_err_sel;

`ifdef MUXN_ERR_CNT_EN
    // ------------------------------------------------------------------
    // Saturating out-of-range beat counter. Clear and count on the same
    // edge leave exactly the new beat counted.
    // ------------------------------------------------------------------
    logic [MUXN_ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_err_cnt <= '0;
        end else if (w_err_hit) begin
            if (CLR_ERR) begin
                r_err_cnt <= MUXN_ERR_CNT_W'(1);
            end else if (r_err_cnt != {MUXN_ERR_CNT_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + MUXN_ERR_CNT_W'(1);
            end
        end else if (CLR_ERR) begin
            r_err_cnt <= '0;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

endmodule : muxn_reg
`default_nettype wire

// File: doc/muxn_reg.md
Name: muxn_reg

Overview:
- Parametrised N:1 operand-select multiplexer with a registered output and a valid/ready handshake.
- Successor to the fixed 16-bit combinational 5:1 datapath mux.
- Adds configurable width and input count, a deterministic out-of-range result, and a sticky select-error flag.
- 2-entry skid buffer, so datapath stages can stall without dropping operands.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 5, number of inputs; legal range 2..16.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NUM_IN.
- DEFAULT_VAL, 16'h0000, value output when the select is out of range.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous active-low reset.
- I  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- S  in  SEL_W  select, sampled with the input beat.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  block can accept a beat.
- O  out  WIDTH  selected data, registered.
- OUT_VALID  out  1  O holds a valid beat.
- OUT_READY  in  1  downstream accepts O.
- SEL_ERR  out  1  sticky: an out-of-range select was accepted.
- ERR_SEL  out  SEL_W  select value of the most recent out-of-range beat.
- CLR_ERR  in  1  synchronous clear of SEL_ERR and ERR_SEL.

Behaviour:
- Clock and reset: single clock CLK. RESET_N is asynchronous, active-low; assertion takes effect immediately, release is synchronous to CLK.
- Reset values: O=0, OUT_VALID=0, IN_READY=1, SEL_ERR=0, ERR_SEL=0; skid entry empty. Reset mid-transfer drops all held beats with no output.
- Transfers: input accepted when IN_VALID && IN_READY at a CLK edge; output consumed when OUT_VALID && OUT_READY.
- Select: data = I[S] when S < NUM_IN, else DEFAULT_VAL. Selection is computed from the S/I values at the accept edge.
- Latency: 1 cycle. A beat accepted at edge n appears on O with OUT_VALID=1 after edge n.
- Storage: main register drives O; a skid register catches a beat accepted while main is full and not draining.
- IN_READY: registered, equals NOT skid_valid. It must not depend combinationally on OUT_READY.
- Main register transitions, per edge:
  - empty + accept: load main.
  - full + consume + accept: load main from skid if skid is occupied (the new beat goes to skid), otherwise from the new beat.
  - full + no consume + accept: new beat goes to skid, IN_READY falls.
  - full + consume + no accept: main loads from skid if occupied, else becomes empty.
- Ordering: strict FIFO order; no beat is ever dropped or duplicated. Throughput is 1 beat/cycle when OUT_READY is held high.
- O stability: O and OUT_VALID stay stable while OUT_VALID && !OUT_READY.
- Errors:
  - Accepting a beat with S >= NUM_IN sets SEL_ERR=1 and ERR_SEL=S on the same edge. The beat still passes through, carrying DEFAULT_VAL.
  - CLR_ERR clears both on the next edge.
  - If CLR_ERR coincides with an erroring accept, the set wins and ERR_SEL takes the new S.
- Exact fit: with NUM_IN = 2^SEL_W, no select is out of range and SEL_ERR is never set.

Optional Feature:
- Macro: MUXN_ERR_CNT_EN.
- When defined: adds output port ERR_CNT (8 bits). It increments on every accepted out-of-range beat, saturates at 255, resets to 0, and is cleared by CLR_ERR. A set on the same edge as CLR_ERR gives 1.
- When undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared datapath package holds:
  - select-width helper function (clog2 of NUM_IN);
  - DEFAULT_VAL constant;
  - MUXN_ERR_CNT_W = 8.
- One natural sub-module, muxn_skid: a generic WIDTH-bit 2-entry skid buffer holding the registered handshake logic. muxn_reg instantiates the combinational select, the error logic and one muxn_skid.

Test Plan:
- Reset, then I0..I4 = 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555 with S=3 and OUT_READY=1 -> O=16'h4444 with OUT_VALID one cycle after accept.
- Streaming S = 0,1,2,3,4 over consecutive cycles with OUT_READY=1 -> O = 1111, 2222, 3333, 4444, 5555 on consecutive cycles; IN_READY stays 1.
- OUT_READY=0 while sending S=1 then S=2 -> IN_READY falls after the 2nd accept; O holds 2222 stable. Raising OUT_READY then yields 2222 followed by 3333, none lost.
- S=6 accepted -> O=16'h0000, SEL_ERR=1, ERR_SEL=6. A later CLR_ERR pulse -> both return to 0. CLR_ERR together with an S=7 accept -> SEL_ERR=1, ERR_SEL=7.
- RESET_N pulsed low mid-stream with both entries full -> OUT_VALID=0 and IN_READY=1 immediately; no stale beats after release.
- With MUXN_ERR_CNT_EN defined, 300 out-of-range beats -> ERR_CNT=255; CLR_ERR -> 0.
